// File: rtl/can_pkg.sv
// Shared types and bit-length constants for the CAN error/overload frame sequencer.
package can_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLAG     = 2'd1,
    S_WAIT_REC = 2'd2,
    S_DELIM    = 2'd3
  } state_e;

  typedef enum logic {
    FT_ERR = 1'b0,
    FT_OVL = 1'b1
  } frame_type_e;

  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] FLAG_LEN         = 4'd6;
  localparam logic [CNT_W-1:0] DELIM_LEN        = 4'd8;
  localparam logic [CNT_W-1:0] EXTRA_DOM_FIRST  = 4'd14;
  localparam logic [CNT_W-1:0] EXTRA_DOM_STEP   = 4'd8;

  // After the first 14-bit pulse the counter restarts here so the next pulse lands 8 bits later.
  localparam logic [CNT_W-1:0] EXTRA_DOM_RELOAD = EXTRA_DOM_FIRST - EXTRA_DOM_STEP;
  // Last delimiter bit: a dominant sample here is an overload condition, not a form error.
  localparam logic [CNT_W-1:0] DELIM_LAST       = DELIM_LEN - 4'd1;

endpackage

// File: rtl/can_err_frame_seq_if.sv
// Bit-level bus between the protocol FSM and the error/overload frame sequencer.
interface can_err_frame_seq_if;

  logic sample_point_i;
  logic sampled_bit_i;
  logic start_error_i;
  logic start_overload_i;
  logic error_passive_i;
  logic overload_req_i;
  logic reset_mode_i;

  logic tx_dominant_o;
  logic error_frame_ended_o;
  logic overload_frame_ended_o;
  logic overload_request_o;
  logic overload_cond_o;
  logic form_err_o;
  logic extra_dom_o;

  modport master (
    output sample_point_i, sampled_bit_i, start_error_i, start_overload_i,
           error_passive_i, overload_req_i, reset_mode_i,
    input  tx_dominant_o, error_frame_ended_o, overload_frame_ended_o,
           overload_request_o, overload_cond_o, form_err_o, extra_dom_o
  );

  modport slave (
    input  sample_point_i, sampled_bit_i, start_error_i, start_overload_i,
           error_passive_i, overload_req_i, reset_mode_i,
    output tx_dominant_o, error_frame_ended_o, overload_frame_ended_o,
           overload_request_o, overload_cond_o, form_err_o, extra_dom_o
  );

endinterface

// File: rtl/can_consec_bit_cnt.sv
// Saturating bit counter with clear and load; clear beats load beats increment.
module can_consec_bit_cnt #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] SAT_VAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  // Count register; holds at SAT_VAL instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (inc_i && (cnt_q != SAT_VAL)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/can_err_frame_seq.sv
// Error / overload frame sequencer: flag, wait for recessive, delimiter, overload bookkeeping.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  S_IDLE     | no frame in progress, overload request may be granted
//  S_FLAG     | sending (active) or observing (passive) the 6-bit flag
//  S_WAIT_REC | flag done, counting dominant bits until the first recessive
//  S_DELIM    | counting the 8 recessive delimiter bits
module can_err_frame_seq
  import can_pkg::*;
#(
  parameter int MAX_OVL_FRAMES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  can_err_frame_seq_if.slave bus
);

  localparam int OVL_W = (MAX_OVL_FRAMES < 1) ? 1 : $clog2(MAX_OVL_FRAMES + 1);
  localparam logic [OVL_W-1:0] OVL_MAX = OVL_W'(MAX_OVL_FRAMES);

  logic sp, bit_rx;
  assign sp     = bus.sample_point_i;
  assign bit_rx = bus.sampled_bit_i;

  state_e             state_q, state_d;
  frame_type_e        type_q, type_d;
  logic               passive_q, passive_d;
  logic               last_bit_q, last_bit_d;
  logic [OVL_W-1:0]   ovl_cnt_q, ovl_cnt_d;
  logic               ovl_req_q, ovl_req_d;

  logic tx_dom_q, err_end_q, ovl_end_q, ovl_cond_q, form_err_q, extra_dom_q;
  logic err_end_d, ovl_end_d, ovl_cond_d, form_err_d, extra_dom_d;

  logic             flg_clr, flg_load, flg_inc;
  logic             dom_clr, dom_load, dom_inc;
  logic             dlm_clr, dlm_load, dlm_inc;
  logic [CNT_W-1:0] flg_cnt, dom_cnt, dlm_cnt;
  logic [CNT_W-1:0] flg_nxt, dom_nxt, dlm_nxt, flg_new;

  assign flg_nxt = flg_cnt + 1'b1;
  assign dom_nxt = dom_cnt + 1'b1;
  assign dlm_nxt = dlm_cnt + 1'b1;

  can_consec_bit_cnt #(.WIDTH(CNT_W), .SAT_VAL(FLAG_LEN)) u_flg_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (flg_clr),
    .load_i     (flg_load),
    .load_val_i (4'd1),
    .inc_i      (flg_inc),
    .cnt_o      (flg_cnt)
  );

  can_consec_bit_cnt #(.WIDTH(CNT_W), .SAT_VAL(EXTRA_DOM_FIRST)) u_dom_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (dom_clr),
    .load_i     (dom_load),
    .load_val_i (EXTRA_DOM_RELOAD),
    .inc_i      (dom_inc),
    .cnt_o      (dom_cnt)
  );

  can_consec_bit_cnt #(.WIDTH(CNT_W), .SAT_VAL(DELIM_LEN)) u_dlm_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (dlm_clr),
    .load_i     (dlm_load),
    .load_val_i (4'd1),
    .inc_i      (dlm_inc),
    .cnt_o      (dlm_cnt)
  );

  // Next state, counter controls, output pulses and overload bookkeeping.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    passive_d   = passive_q;
    last_bit_d  = last_bit_q;
    ovl_cnt_d   = ovl_cnt_q;
    ovl_req_d   = ovl_req_q;
    flg_clr     = 1'b0;
    flg_load    = 1'b0;
    flg_inc     = 1'b0;
    flg_new     = flg_cnt;
    dom_clr     = 1'b0;
    dom_load    = 1'b0;
    dom_inc     = 1'b0;
    dlm_clr     = 1'b0;
    dlm_load    = 1'b0;
    dlm_inc     = 1'b0;
    err_end_d   = 1'b0;
    ovl_end_d   = 1'b0;
    ovl_cond_d  = 1'b0;
    form_err_d  = 1'b0;
    extra_dom_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_overload_i) begin
          state_d   = S_FLAG;
          type_d    = FT_OVL;
          passive_d = 1'b0;
          flg_clr   = 1'b1;
        end
      end
      S_FLAG: begin
        if (sp) begin
          last_bit_d = bit_rx;
          // Active flags just count bits; a passive flag needs 6 equal bits in a row.
          if (!passive_q || (flg_cnt == '0) || (bit_rx == last_bit_q)) begin
            flg_inc = 1'b1;
            flg_new = flg_nxt;
          end else begin
            flg_load = 1'b1;
            flg_new  = 4'd1;
          end
          if (flg_new == FLAG_LEN) begin
            state_d = S_WAIT_REC;
            flg_clr = 1'b1;
          end
        end
      end
      S_WAIT_REC: begin
        if (sp) begin
          if (!bit_rx) begin
            if (dom_nxt == EXTRA_DOM_FIRST) begin
              extra_dom_d = 1'b1;
              dom_load    = 1'b1;
            end else begin
              dom_inc = 1'b1;
            end
          end else begin
            state_d  = S_DELIM;
            dom_clr  = 1'b1;
            dlm_load = 1'b1;
          end
        end
      end
      S_DELIM: begin
        if (sp) begin
          if (bit_rx) begin
            if (dlm_nxt == DELIM_LEN) begin
              err_end_d = (type_q == FT_ERR);
              ovl_end_d = (type_q == FT_OVL);
              state_d   = S_IDLE;
              dlm_clr   = 1'b1;
            end else begin
              dlm_inc = 1'b1;
            end
          end else begin
            ovl_cond_d = (dlm_cnt == DELIM_LAST);
            form_err_d = (dlm_cnt != DELIM_LAST);
            state_d    = S_IDLE;
            dlm_clr    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new error always restarts the flag, whatever was in progress.
    if (bus.start_error_i) begin
      state_d     = S_FLAG;
      type_d      = FT_ERR;
      passive_d   = bus.error_passive_i;
      flg_clr     = 1'b1;
      dom_clr     = 1'b1;
      dlm_clr     = 1'b1;
      err_end_d   = 1'b0;
      ovl_end_d   = 1'b0;
      ovl_cond_d  = 1'b0;
      form_err_d  = 1'b0;
      extra_dom_d = 1'b0;
    end

    if (bus.start_overload_i && (state_q == S_IDLE) && !bus.start_error_i &&
        (ovl_cnt_q != OVL_MAX)) begin
      ovl_cnt_d = ovl_cnt_q + 1'b1;
    end
    if (bus.start_overload_i) begin
      ovl_req_d = 1'b0;
    end else if ((state_q == S_IDLE) && bus.overload_req_i && (ovl_cnt_q < OVL_MAX)) begin
      ovl_req_d = 1'b1;
    end
    if (err_end_d || ((state_q == S_IDLE) && sp && !bus.overload_req_i)) begin
      ovl_cnt_d = '0;
    end

    if (bus.reset_mode_i) begin
      state_d     = S_IDLE;
      passive_d   = 1'b0;
      flg_clr     = 1'b1;
      dom_clr     = 1'b1;
      dlm_clr     = 1'b1;
      ovl_cnt_d   = '0;
      ovl_req_d   = 1'b0;
      err_end_d   = 1'b0;
      ovl_end_d   = 1'b0;
      ovl_cond_d  = 1'b0;
      form_err_d  = 1'b0;
      extra_dom_d = 1'b0;
    end
  end

  // State and registered outputs; tx follows the state being entered so it is never late.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      type_q      <= FT_ERR;
      passive_q   <= 1'b0;
      last_bit_q  <= 1'b0;
      ovl_cnt_q   <= '0;
      ovl_req_q   <= 1'b0;
      tx_dom_q    <= 1'b0;
      err_end_q   <= 1'b0;
      ovl_end_q   <= 1'b0;
      ovl_cond_q  <= 1'b0;
      form_err_q  <= 1'b0;
      extra_dom_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      passive_q   <= passive_d;
      last_bit_q  <= last_bit_d;
      ovl_cnt_q   <= ovl_cnt_d;
      ovl_req_q   <= ovl_req_d;
      tx_dom_q    <= (state_d == S_FLAG) && !passive_d;
      err_end_q   <= err_end_d;
      ovl_end_q   <= ovl_end_d;
      ovl_cond_q  <= ovl_cond_d;
      form_err_q  <= form_err_d;
      extra_dom_q <= extra_dom_d;
    end
  end

  assign bus.tx_dominant_o          = tx_dom_q;
  assign bus.error_frame_ended_o    = err_end_q;
  assign bus.overload_frame_ended_o = ovl_end_q;
  assign bus.overload_request_o     = ovl_req_q;
  assign bus.overload_cond_o        = ovl_cond_q;
  assign bus.form_err_o             = form_err_q;
  assign bus.extra_dom_o            = extra_dom_q;

endmodule

// File: tb/tb_can_err_frame_seq.sv
// Scoreboard bench for can_err_frame_seq: directed frames, pulses checked by a negedge monitor.
module tb_can_err_frame_seq;
  import can_pkg::*;

  localparam logic [4:0] P_NONE     = 5'b00000;
  localparam logic [4:0] P_ERR_END  = 5'b10000;
  localparam logic [4:0] P_OVL_END  = 5'b01000;
  localparam logic [4:0] P_OVL_COND = 5'b00100;
  localparam logic [4:0] P_FORM     = 5'b00010;
  localparam logic [4:0] P_EXTRA    = 5'b00001;

  typedef struct {
    logic [4:0] vec;
    int         idx;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  can_err_frame_seq_if bus ();

  can_err_frame_seq #(.MAX_OVL_FRAMES(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   sp_idx = 0;
  int   sp_cap_cyc = -10;
  exp_t expq[$];
  logic txq[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops an expected pulse whenever the DUT shows one, and an expected tx level at every sample point.
  always @(negedge clk_i) begin
    logic [4:0] v;
    exp_t       e;
    logic       t;
    if (!rst_i) begin
      v = {bus.error_frame_ended_o, bus.overload_frame_ended_o, bus.overload_cond_o,
           bus.form_err_o, bus.extra_dom_o};
      if (v != P_NONE) begin
        if (expq.size() == 0) begin
          chk("unexpected_pulse", 32'(v), 32'(P_NONE));
        end else begin
          e = expq.pop_front();
          chk("pulse_kind", 32'(v), 32'(e.vec));
          chk("pulse_after_sample", sp_idx, e.idx);
          chk("pulse_one_cycle_after_sample", cyc, sp_cap_cyc);
        end
      end
      if (bus.sample_point_i) begin
        if (txq.size() == 0) begin
          chk("tx_unscheduled_sample", 32'(bus.tx_dominant_o), 32'd0);
        end else begin
          t = txq.pop_front();
          chk("tx_dominant_at_sample", 32'(bus.tx_dominant_o), 32'(t));
        end
      end
    end
  end

  task automatic samp(input logic b, input logic tx, input logic [4:0] pv);
    exp_t e;
    txq.push_back(tx);
    if (pv != P_NONE) begin
      e.vec = pv;
      e.idx = sp_idx + 1;
      expq.push_back(e);
    end
    @(posedge clk_i); #1;
    bus.sample_point_i = 1'b1;
    bus.sampled_bit_i  = b;
    @(posedge clk_i); #1;
    bus.sample_point_i = 1'b0;
    bus.sampled_bit_i  = 1'b1;
    sp_idx++;
    sp_cap_cyc = cyc;
    repeat (2) @(posedge clk_i);
  endtask

  task automatic samps(input int n, input logic b, input logic tx);
    for (int i = 0; i < n; i++) samp(b, tx, P_NONE);
  endtask

  task automatic pulse_start(input logic err, input logic ovl);
    @(posedge clk_i); #1;
    bus.start_error_i    = err;
    bus.start_overload_i = ovl;
    @(posedge clk_i); #1;
    bus.start_error_i    = 1'b0;
    bus.start_overload_i = 1'b0;
  endtask

  task automatic pulse_reset_mode();
    @(posedge clk_i); #1;
    bus.reset_mode_i = 1'b1;
    @(posedge clk_i); #1;
    bus.reset_mode_i = 1'b0;
  endtask

  task automatic wait_req(input logic level);
    int n;
    n = 0;
    while ((bus.overload_request_o !== level) && (n < 20)) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("overload_request_wait", 32'(bus.overload_request_o), 32'(level));
  endtask

  // Complete frame tail: 8 recessive bits, the end pulse after the last.
  task automatic delim_ok(input logic [4:0] end_pulse);
    samps(7, 1'b1, 1'b0);
    samp(1'b1, 1'b0, end_pulse);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_point_i   = 1'b0;
    bus.sampled_bit_i    = 1'b1;
    bus.start_error_i    = 1'b0;
    bus.start_overload_i = 1'b0;
    bus.error_passive_i  = 1'b0;
    bus.overload_req_i   = 1'b0;
    bus.reset_mode_i     = 1'b0;

    // Reset values, then quiet after release.
    repeat (3) @(posedge clk_i); #1;
    chk("reset_outputs", 32'({bus.tx_dominant_o, bus.error_frame_ended_o, bus.overload_frame_ended_o,
        bus.overload_request_o, bus.overload_cond_o, bus.form_err_o, bus.extra_dom_o}), 32'd0);
    chk("reset_state", 32'(dut.state_q), 32'(S_IDLE));
    chk("reset_type", 32'(dut.type_q), 32'(FT_ERR));
    rst_i = 1'b0;
    repeat (5) @(posedge clk_i); #1;
    chk("post_reset_quiet", 32'({bus.tx_dominant_o, bus.overload_request_o}), 32'd0);

    // Active error frame: 6 dominant flag bits, 8 recessive, ended pulse after the 14th sample.
    pulse_start(1'b1, 1'b0);
    chk("active_flag_tx_on_entry", 32'(bus.tx_dominant_o), 32'd1);
    samps(6, 1'b0, 1'b1);
    delim_ok(P_ERR_END);
    chk("active_err_back_idle", 32'(dut.state_q), 32'(S_IDLE));

    // Passive error flag: 1,1,0,0,0,0,0,0 leaves the flag on the 8th sample.
    bus.error_passive_i = 1'b1;
    pulse_start(1'b1, 1'b0);
    bus.error_passive_i = 1'b0;
    samps(2, 1'b1, 1'b0);
    samps(5, 1'b0, 1'b0);
    chk("passive_still_flag_after_7", 32'(dut.state_q), 32'(S_FLAG));
    samp(1'b0, 1'b0, P_NONE);
    chk("passive_wait_rec_after_8", 32'(dut.state_q), 32'(S_WAIT_REC));
    delim_ok(P_ERR_END);

    // 22 dominant bits after the flag: extra_dom after the 14th and 22nd.
    pulse_start(1'b1, 1'b0);
    samps(6, 1'b0, 1'b1);
    samps(13, 1'b0, 1'b0);
    samp(1'b0, 1'b0, P_EXTRA);
    samps(7, 1'b0, 1'b0);
    samp(1'b0, 1'b0, P_EXTRA);
    delim_ok(P_ERR_END);

    // Overload frame, dominant at delimiter bit 4: form error and back to idle.
    pulse_start(1'b0, 1'b1);
    samps(6, 1'b0, 1'b1);
    samps(3, 1'b1, 1'b0);
    samp(1'b0, 1'b0, P_FORM);
    chk("form_err_back_idle", 32'(dut.state_q), 32'(S_IDLE));

    // Error frame, dominant at delimiter bit 8: overload condition, no ended pulse.
    pulse_start(1'b1, 1'b0);
    samps(6, 1'b0, 1'b1);
    samps(7, 1'b1, 1'b0);
    samp(1'b0, 1'b0, P_OVL_COND);
    chk("ovl_cond_back_idle", 32'(dut.state_q), 32'(S_IDLE));

    // Held overload request with a limit of 2: two frames, then the request stays low.
    pulse_reset_mode();
    bus.overload_req_i = 1'b1;
    for (int f = 0; f < 2; f++) begin
      wait_req(1'b1);
      pulse_start(1'b0, 1'b1);
      chk("ovl_req_falls_on_start", 32'(bus.overload_request_o), 32'd0);
      samps(6, 1'b0, 1'b1);
      delim_ok(P_OVL_END);
    end
    repeat (10) @(posedge clk_i); #1;
    chk("ovl_req_low_after_limit", 32'(bus.overload_request_o), 32'd0);
    bus.overload_req_i = 1'b0;
    samp(1'b1, 1'b0, P_NONE);
    bus.overload_req_i = 1'b1;
    wait_req(1'b1);
    bus.overload_req_i = 1'b0;
    pulse_reset_mode();
    chk("reset_mode_clears_request", 32'(bus.overload_request_o), 32'd0);

    // Error at overload delimiter bit 3 restarts as an error frame; late start_overload is ignored.
    pulse_start(1'b0, 1'b1);
    samps(6, 1'b0, 1'b1);
    samps(2, 1'b1, 1'b0);
    pulse_start(1'b1, 1'b0);
    chk("restart_state_flag", 32'(dut.state_q), 32'(S_FLAG));
    chk("restart_type_err", 32'(dut.type_q), 32'(FT_ERR));
    chk("restart_tx_dominant", 32'(bus.tx_dominant_o), 32'd1);
    samps(2, 1'b0, 1'b1);
    pulse_start(1'b0, 1'b1);
    samps(4, 1'b0, 1'b1);
    delim_ok(P_ERR_END);

    // Simultaneous starts choose ERR; reset_mode mid-flag drops tx and returns to idle.
    pulse_start(1'b1, 1'b1);
    chk("both_starts_type_err", 32'(dut.type_q), 32'(FT_ERR));
    samps(3, 1'b0, 1'b1);
    pulse_reset_mode();
    chk("reset_mode_tx_low", 32'(bus.tx_dominant_o), 32'd0);
    chk("reset_mode_state_idle", 32'(dut.state_q), 32'(S_IDLE));

    repeat (10) @(posedge clk_i); #1;
    chk("pending_expected_pulses", expq.size(), 0);
    chk("pending_expected_tx", txq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
